// File: rtl/cpu65_int_ctrl_if.sv
// Interrupt sequencer bus between the 65xx core (master) and cpu65_int_ctrl (slave).
interface cpu65_int_ctrl_if #(
    parameter int NUM_IRQ = 4
);
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [NUM_IRQ-1:0] irq_in;
    logic               nmi_in;
    logic               i_flag;
    logic               brk_in;
    logic               int_ack;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_wdata;
    logic               int_req;
    logic [15:0]        vec_addr;
    logic [1:0]         vec_kind;
    logic [IDW-1:0]     irq_id;
    logic               b_flag;
    logic [NUM_IRQ-1:0] irq_pending;

    modport master (
        output irq_in, nmi_in, i_flag, brk_in, int_ack, mask_we, mask_wdata,
        input  int_req, vec_addr, vec_kind, irq_id, b_flag, irq_pending
    );

    modport slave (
        input  irq_in, nmi_in, i_flag, brk_in, int_ack, mask_we, mask_wdata,
        output int_req, vec_addr, vec_kind, irq_id, b_flag, irq_pending
    );
endinterface

// File: rtl/cpu65_int_ctrl.sv
// RESET/NMI/BRK/IRQ arbiter and vector sequencer for the 65xx core.
// Captures the serviced source on int_ack; the core then fetches vec_addr.
module cpu65_int_ctrl #(
    parameter int                 NUM_IRQ    = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK  = '0,
    parameter bit                 VECTORED   = 1'b0,
    parameter logic [15:0]        IRQ_TABLE  = 16'hFFE0,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = '1
) (
    input logic             clk,
    input logic             reset_n,
    cpu65_int_ctrl_if.slave bus
);
    localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        KIND_RESET = 2'd0,
        KIND_NMI   = 2'd1,
        KIND_IRQ   = 2'd2,
        KIND_BRK   = 2'd3
    } kind_t;

    logic               reset_pend;
    logic               nmi_pend;
    logic               nmi_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] mask;

    logic               nmi_rise;
    logic               nmi_clr;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_elig;
    logic [NUM_IRQ-1:0] winner_oh;
    logic [NUM_IRQ-1:0] edge_clr;
    logic [IDW-1:0]     winner_id;

    always_comb begin
        nmi_rise  = bus.nmi_in & ~nmi_q;
        irq_rise  = bus.irq_in & ~irq_q;
        pending   = (edge_pend & EDGE_MASK) | (irq_q & ~EDGE_MASK);
        irq_elig  = pending & mask & {NUM_IRQ{~bus.i_flag}};
        winner_oh = irq_elig & (~irq_elig + NUM_IRQ'(1));
    end

    // Descending scan so the lowest eligible index is written last and wins.
    always_comb begin
        winner_id = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_elig[k]) winner_id = IDW'(k);
        end
    end

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        nmi_clr  = 1'b0;
        edge_clr = '0;
        if (bus.int_ack && !reset_pend) begin
            if (nmi_pend)
                nmi_clr = 1'b1;
            else if (!bus.brk_in)
                edge_clr = winner_oh & EDGE_MASK;
        end
    end

    assign bus.int_req     = reset_pend | nmi_pend | (|irq_elig);
    assign bus.irq_pending = pending;

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reset_pend   <= 1'b1;
            nmi_pend     <= 1'b0;
            nmi_q        <= 1'b0;
            irq_q        <= '0;
            edge_pend    <= '0;
            mask         <= MASK_RESET;
            bus.vec_addr <= 16'hFFFC;
            bus.vec_kind <= KIND_RESET;
            bus.irq_id   <= '0;
            bus.b_flag   <= 1'b0;
        end else begin
            irq_q <= bus.irq_in;
            nmi_q <= bus.nmi_in;
            // Set is OR'd after clear so a new edge in the ack cycle stays pending.
            nmi_pend  <= (nmi_pend & ~nmi_clr) | nmi_rise;
            edge_pend <= (edge_pend & ~edge_clr) | (irq_rise & EDGE_MASK);
            if (bus.mask_we) mask <= bus.mask_wdata;

            if (bus.int_ack) begin
                if (reset_pend) begin
                    reset_pend   <= 1'b0;
                    bus.vec_addr <= 16'hFFFC;
                    bus.vec_kind <= KIND_RESET;
                    bus.b_flag   <= 1'b0;
                end else if (nmi_pend) begin
                    // BRK hijack: BRK bytes already consumed, but NMI vector is used.
                    bus.vec_addr <= 16'hFFFA;
                    bus.vec_kind <= KIND_NMI;
                    bus.b_flag   <= bus.brk_in;
                end else if (bus.brk_in) begin
                    bus.vec_addr <= 16'hFFFE;
                    bus.vec_kind <= KIND_BRK;
                    bus.b_flag   <= 1'b1;
                end else if (|irq_elig) begin
                    bus.vec_addr <= VECTORED ? (IRQ_TABLE + (16'(winner_id) << 1)) : 16'hFFFE;
                    bus.vec_kind <= KIND_IRQ;
                    bus.irq_id   <= winner_id;
                    bus.b_flag   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu65_int_ctrl.sv
// Directed bench: dut0 is non-vectored with channel 0 edge-latched, dut1 is vectored and all-level.
module tb_cpu65_int_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cpu65_int_ctrl_if #(.NUM_IRQ(4)) if0 ();
    cpu65_int_ctrl_if #(.NUM_IRQ(4)) if1 ();

    cpu65_int_ctrl #(
        .NUM_IRQ(4), .EDGE_MASK(4'b0001), .VECTORED(1'b0),
        .IRQ_TABLE(16'hFFE0), .MASK_RESET(4'hF)
    ) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));

    cpu65_int_ctrl #(
        .NUM_IRQ(4), .EDGE_MASK(4'b0000), .VECTORED(1'b1),
        .IRQ_TABLE(16'hFFE0), .MASK_RESET(4'hF)
    ) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

    typedef struct {
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        i_flag;
        logic        exp_req;
        logic [1:0]  exp_id;
        logic [15:0] exp_vec1;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ack0(input logic brk);
        if0.int_ack = 1'b1;
        if0.brk_in  = brk;
        tick();
        if0.int_ack = 1'b0;
        if0.brk_in  = 1'b0;
    endtask

    task automatic ack_both();
        if0.int_ack = 1'b1;
        if1.int_ack = 1'b1;
        tick();
        if0.int_ack = 1'b0;
        if1.int_ack = 1'b0;
    endtask

    task automatic check_cap0(input string name, input logic [1:0] kind,
                              input logic [15:0] vec, input logic b);
        check({name, ".kind"}, 16'(if0.vec_kind), 16'(kind));
        check({name, ".vec"},  if0.vec_addr, vec);
        check({name, ".b"},    16'(if0.b_flag), 16'(b));
    endtask

    initial begin
        tbl[0] = '{irq: 4'b1010, mask: 4'hF,    i_flag: 1'b0, exp_req: 1'b1, exp_id: 2'd1, exp_vec1: 16'hFFE2};
        tbl[1] = '{irq: 4'b1010, mask: 4'hF,    i_flag: 1'b1, exp_req: 1'b0, exp_id: 2'd0, exp_vec1: 16'h0000};
        tbl[2] = '{irq: 4'b1010, mask: 4'b1000, i_flag: 1'b0, exp_req: 1'b1, exp_id: 2'd3, exp_vec1: 16'hFFE6};
        tbl[3] = '{irq: 4'b0100, mask: 4'hF,    i_flag: 1'b0, exp_req: 1'b1, exp_id: 2'd2, exp_vec1: 16'hFFE4};
        tbl[4] = '{irq: 4'b0110, mask: 4'b0010, i_flag: 1'b0, exp_req: 1'b1, exp_id: 2'd1, exp_vec1: 16'hFFE2};
        tbl[5] = '{irq: 4'b1110, mask: 4'b0000, i_flag: 1'b0, exp_req: 1'b0, exp_id: 2'd0, exp_vec1: 16'h0000};

        if0.irq_in = '0; if0.nmi_in = 1'b0; if0.i_flag = 1'b0; if0.brk_in = 1'b0;
        if0.int_ack = 1'b0; if0.mask_we = 1'b0; if0.mask_wdata = '0;
        if1.irq_in = '0; if1.nmi_in = 1'b0; if1.i_flag = 1'b0; if1.brk_in = 1'b0;
        if1.int_ack = 1'b0; if1.mask_we = 1'b0; if1.mask_wdata = '0;

        // Reset state and the RESET acknowledge.
        tick();
        tick();
        reset_n = 1'b1;
        check("rst.int_req0", 16'(if0.int_req), 16'd1);
        check("rst.int_req1", 16'(if1.int_req), 16'd1);
        check_cap0("rst", 2'd0, 16'hFFFC, 1'b0);
        check("rst.irq_id", 16'(if0.irq_id), 16'd0);
        check("rst.pending", 16'(if0.irq_pending), 16'd0);
        tick();
        check("rst.held_req", 16'(if0.int_req), 16'd1);
        ack_both();
        check_cap0("rst_ack", 2'd0, 16'hFFFC, 1'b0);
        check("rst_ack.int_req0", 16'(if0.int_req), 16'd0);
        check("rst_ack.int_req1", 16'(if1.int_req), 16'd0);

        // NMI held high for 10 cycles yields exactly one NMI.
        if0.nmi_in = 1'b1;
        tick();
        check("nmi.req", 16'(if0.int_req), 16'd1);
        ack0(1'b0);
        check_cap0("nmi1", 2'd1, 16'hFFFA, 1'b0);
        begin
            int high_cycles = 0;
            for (int c = 0; c < 8; c++) begin
                if (if0.int_req) high_cycles++;
                tick();
            end
            check("nmi.held_no_retrigger", 16'(high_cycles), 16'd0);
        end
        if0.nmi_in = 1'b0;
        tick();
        check("nmi.low_req", 16'(if0.int_req), 16'd0);
        if0.nmi_in = 1'b1;
        tick();
        check("nmi.rearm_req", 16'(if0.int_req), 16'd1);
        ack0(1'b0);
        check_cap0("nmi2", 2'd1, 16'hFFFA, 1'b0);
        check("nmi2.req", 16'(if0.int_req), 16'd0);
        if0.nmi_in = 1'b0;
        tick();

        // BRK hijacked by a pending NMI, then plain BRK, then a spurious ack.
        if0.nmi_in = 1'b1;
        tick();
        ack0(1'b1);
        check_cap0("brk_hijack", 2'd1, 16'hFFFA, 1'b1);
        if0.nmi_in = 1'b0;
        tick();
        check("brk.req_idle", 16'(if0.int_req), 16'd0);
        ack0(1'b1);
        check_cap0("brk", 2'd3, 16'hFFFE, 1'b1);
        ack0(1'b0);
        check_cap0("spurious", 2'd3, 16'hFFFE, 1'b1);

        // IRQ arbitration table, applied to both instances.
        for (int v = 0; v < 6; v++) begin
            if0.mask_we = 1'b1; if0.mask_wdata = tbl[v].mask;
            if1.mask_we = 1'b1; if1.mask_wdata = tbl[v].mask;
            if0.irq_in = tbl[v].irq; if1.irq_in = tbl[v].irq;
            if0.i_flag = tbl[v].i_flag; if1.i_flag = tbl[v].i_flag;
            tick();
            if0.mask_we = 1'b0; if1.mask_we = 1'b0;
            check($sformatf("v%0d.req0", v), 16'(if0.int_req), 16'(tbl[v].exp_req));
            check($sformatf("v%0d.req1", v), 16'(if1.int_req), 16'(tbl[v].exp_req));
            if (tbl[v].exp_req) begin
                ack_both();
                check_cap0($sformatf("v%0d", v), 2'd2, 16'hFFFE, 1'b0);
                check($sformatf("v%0d.id0", v), 16'(if0.irq_id), 16'(tbl[v].exp_id));
                check($sformatf("v%0d.kind1", v), 16'(if1.vec_kind), 16'd2);
                check($sformatf("v%0d.id1", v), 16'(if1.irq_id), 16'(tbl[v].exp_id));
                check($sformatf("v%0d.vec1", v), if1.vec_addr, tbl[v].exp_vec1);
            end
            if0.irq_in = '0; if1.irq_in = '0;
            if0.i_flag = 1'b0; if1.i_flag = 1'b0;
            tick();
        end

        // Ack in the same cycle as a mask write arbitrates with the old mask.
        if0.mask_we = 1'b1; if0.mask_wdata = 4'hF; if0.irq_in = 4'b0010;
        tick();
        check("mask_race.req_before", 16'(if0.int_req), 16'd1);
        if0.mask_wdata = 4'h0;
        ack0(1'b0);
        if0.mask_we = 1'b0;
        check_cap0("mask_race", 2'd2, 16'hFFFE, 1'b0);
        check("mask_race.id", 16'(if0.irq_id), 16'd1);
        check("mask_race.req_after", 16'(if0.int_req), 16'd0);
        if0.irq_in = '0; if0.mask_we = 1'b1; if0.mask_wdata = 4'hF;
        tick();
        if0.mask_we = 1'b0;

        // Edge channel 0: latching, set-beats-clear, and final clear.
        if0.irq_in = 4'b0001;
        tick();
        check("edge.pend_set", 16'(if0.irq_pending), 16'b0001);
        if0.irq_in = 4'b0000;
        tick();
        check("edge.pend_latched", 16'(if0.irq_pending), 16'b0001);
        if0.irq_in = 4'b0001;
        ack0(1'b0);
        check_cap0("edge1", 2'd2, 16'hFFFE, 1'b0);
        check("edge1.id", 16'(if0.irq_id), 16'd0);
        check("edge1.set_beats_clear", 16'(if0.irq_pending), 16'b0001);
        if0.irq_in = 4'b0000;
        ack0(1'b1);
        check_cap0("edge.brk_between", 2'd3, 16'hFFFE, 1'b1);
        check("edge.brk_keeps_pend", 16'(if0.irq_pending), 16'b0001);
        ack0(1'b0);
        check_cap0("edge2", 2'd2, 16'hFFFE, 1'b0);
        check("edge2.id", 16'(if0.irq_id), 16'd0);
        check("edge2.pend_clear", 16'(if0.irq_pending), 16'd0);
        check("edge2.req", 16'(if0.int_req), 16'd0);

        // Reset in the middle of a pending NMI discards it.
        if0.nmi_in = 1'b1;
        tick();
        check("midrst.nmi_req", 16'(if0.int_req), 16'd1);
        reset_n = 1'b0;
        if0.nmi_in = 1'b0;
        tick();
        reset_n = 1'b1;
        check_cap0("midrst", 2'd0, 16'hFFFC, 1'b0);
        ack_both();
        check_cap0("midrst_ack", 2'd0, 16'hFFFC, 1'b0);
        check("midrst.nmi_discarded", 16'(if0.int_req), 16'd0);
        check("midrst.req1", 16'(if1.int_req), 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
